// File: rtl/peripheral_uart_wb_sequencer.sv
// Wishbone classic master for the 8-bit register port of a 16550-style UART.
// After reset it writes the divisor latch, LCR, FCR and IER. It then polls LSR
// and moves bytes between the THR/RBR registers and two valid/ready streams.
module peripheral_uart_wb_sequencer #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter logic [7:0]  IER_VAL     = 8'h00,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  output logic [3:0] wbm_sel_o,
  input  logic       wbm_ack_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       init_done_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_INIT5,
    S_POLL, S_RXRD, S_TXWR
  } state_t;

  localparam logic [2:0] ADR_RBR_THR = 3'd0;
  localparam logic [2:0] ADR_IER_DLM = 3'd1;
  localparam logic [2:0] ADR_FCR     = 3'd2;
  localparam logic [2:0] ADR_LCR     = 3'd3;
  localparam logic [2:0] ADR_LSR     = 3'd5;

  state_t     state;
  logic       busy;       // a bus cycle is in flight (cyc = stb)
  logic [7:0] tmo_cnt;
  logic       tx_full;
  logic [7:0] tx_hold;

  logic [2:0] req_adr;
  logic [7:0] req_dat;
  logic       req_we;

  logic xfer_done;
  logic tx_take;

  assign wbm_cyc_o  = busy;
  assign wbm_stb_o  = busy;
  assign wbm_sel_o  = 4'b0001;
  assign tx_ready_o = init_done_o && !tx_full;
  assign tx_take    = tx_valid_i && tx_ready_o;
  assign xfer_done  = busy && wbm_ack_i;

  // Bus request (address, data, direction) implied by the current state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    req_adr = ADR_RBR_THR;
    req_dat = 8'h00;
    req_we  = 1'b0;
    case (state)
      S_INIT0: begin req_adr = ADR_LCR;     req_dat = LCR_VAL | 8'h80;   req_we = 1'b1; end
      S_INIT1: begin req_adr = ADR_RBR_THR; req_dat = DIVISOR[7:0];      req_we = 1'b1; end
      S_INIT2: begin req_adr = ADR_IER_DLM; req_dat = DIVISOR[15:8];     req_we = 1'b1; end
      S_INIT3: begin req_adr = ADR_LCR;     req_dat = LCR_VAL & 8'h7F;   req_we = 1'b1; end
      S_INIT4: begin req_adr = ADR_FCR;     req_dat = FCR_VAL;           req_we = 1'b1; end
      S_INIT5: begin req_adr = ADR_IER_DLM; req_dat = IER_VAL;           req_we = 1'b1; end
      S_POLL:  begin req_adr = ADR_LSR; end
      S_RXRD:  begin req_adr = ADR_RBR_THR; end
      S_TXWR:  begin req_adr = ADR_RBR_THR; req_dat = tx_hold;           req_we = 1'b1; end
      default: ;
    endcase
  end

  // Sequencer FSM: start a transfer from idle, finish on ack or on timeout.
  // The cycle after every completion has busy=0, giving the required idle gap.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_INIT0;
      busy        <= 1'b0;
      wbm_adr_o   <= 3'd0;
      wbm_dat_o   <= 8'h00;
      wbm_we_o    <= 1'b0;
      tmo_cnt     <= 8'd0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, independent of statement order.
      err_o <= 1'b0;
      if (!busy) begin
        busy      <= 1'b1;
        wbm_adr_o <= req_adr;
        wbm_dat_o <= req_dat;
        wbm_we_o  <= req_we;
        tmo_cnt   <= 8'd0;
      end else if (wbm_ack_i) begin
        busy     <= 1'b0;
        wbm_we_o <= 1'b0;
        case (state)
          S_INIT0: state <= S_INIT1;
          S_INIT1: state <= S_INIT2;
          S_INIT2: state <= S_INIT3;
          S_INIT3: state <= S_INIT4;
          S_INIT4: state <= S_INIT5;
          S_INIT5: begin
            init_done_o <= 1'b1;
            state       <= S_POLL;
          end
          S_POLL: begin
            // LSR bit 0 = data ready, bit 5 = THR empty; RX wins over TX.
            if (wbm_dat_i[0] && !rx_valid_o)
              state <= S_RXRD;
            else if (wbm_dat_i[5] && tx_full)
              state <= S_TXWR;
            else
              state <= S_POLL;
          end
          default: state <= S_POLL;
        endcase
      end else if (tmo_cnt == ACK_TIMEOUT - 8'd1) begin
        busy     <= 1'b0;
        wbm_we_o <= 1'b0;
        err_o    <= 1'b1;
        state    <= init_done_o ? S_POLL : S_INIT0;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  // TX holding register: filled by the stream handshake, emptied by the THR write ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_full <= 1'b0;
      tx_hold <= 8'h00;
    end else if (tx_take) begin
      tx_full <= 1'b1;
      tx_hold <= tx_data_i;
    end else if (xfer_done && state == S_TXWR) begin
      tx_full <= 1'b0;
    end
  end

  // RX holding register: a completing RBR read wins over a same-cycle consume.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_valid_o <= 1'b0;
      rx_data_o  <= 8'h00;
    end else if (xfer_done && state == S_RXRD) begin
      rx_valid_o <= 1'b1;
      rx_data_o  <= wbm_dat_i;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peripheral_uart_wb_sequencer.sv
// Directed bench for peripheral_uart_wb_sequencer: a registered-ack Wishbone
// slave model logs every completed transfer; checks read from that log.
module tb_peripheral_uart_wb_sequencer;

  localparam int LOGN = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] adr;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       we, stb, cyc, ack = 1'b0;
  logic [3:0] sel;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done;
  logic       err;

  logic       ack_en  = 1'b1;
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;

  int log_adr [LOGN];
  int log_dat [LOGN];
  int log_we  [LOGN];
  int n_xfer    = 0;
  int n_err     = 0;
  int bad_ready = 0;
  int total     = 0;
  int bad       = 0;

  int exp_adr [6] = '{3, 0, 1, 3, 2, 1};
  int exp_dat [6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};

  peripheral_uart_wb_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_we_o    (we),
    .wbm_stb_o   (stb),
    .wbm_cyc_o   (cyc),
    .wbm_sel_o   (sel),
    .wbm_ack_i   (ack),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .init_done_o (init_done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Slave: ack one cycle after strobe; LSR at adr 5, RBR elsewhere.
  assign dat_i = (adr == 3'd5) ? lsr_val : rbr_val;

  always @(posedge clk) begin
    if (cyc && stb && ack && n_xfer < LOGN) begin
      log_adr[n_xfer] = int'(adr);
      log_dat[n_xfer] = int'(dat_o);
      log_we[n_xfer]  = int'(we);
      n_xfer++;
    end
    if (err) n_err++;
    if (tx_ready && !init_done) bad_ready++;
    ack <= ack_en && cyc && stb && !ack;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a logged transfer at index >= from with given adr/we.
  task automatic wait_xfer(input string tag, input int from, input int a, input int w,
                           output int idx);
    idx = -1;
    for (int c = 0; c < 400 && idx < 0; c++) begin
      @(negedge clk);
      for (int k = from; k < n_xfer; k++)
        if (idx < 0 && log_adr[k] == a && log_we[k] == w) idx = k;
    end
    if (idx < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_init(input string tag);
    int c;
    c = 0;
    while (!init_done && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(tag, init_done, 1);
  endtask

  function automatic int count_xfer(input int from, input int a, input int w);
    int n;
    n = 0;
    for (int k = from; k < n_xfer; k++)
      if (log_adr[k] == a && log_we[k] == w) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, iw, ir, cnt, c, err_mark, tmo_adr;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_sel", sel, 4'b0001);
    check("rst_init_done", init_done, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Init sequence: exactly six writes, then init_done
    wait_init("init_wait");
    check("init_count", n_xfer, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("init%0d_adr", i), log_adr[i], exp_adr[i]);
      check($sformatf("init%0d_dat", i), log_dat[i], exp_dat[i]);
      check($sformatf("init%0d_we", i), log_we[i], 1);
    end
    check("early_tx_ready", bad_ready, 0);

    // TX path: byte held while LSR=00, written after a THRE poll
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    check("tx_ready_empty", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_full", tx_ready, 0);
    mark = n_xfer;
    repeat (20) @(negedge clk);
    check("no_wr_lsr00", count_xfer(mark, 0, 1), 0);
    lsr_val = 8'h20;
    wait_xfer("thr_wr", mark, 0, 1, iw);
    if (iw > 0) begin
      check("thr_dat", log_dat[iw], 8'hA5);
      check("thr_prev_adr", log_adr[iw-1], 5);
      check("thr_prev_we", log_we[iw-1], 0);
    end
    check("tx_ready_after", tx_ready, 1);

    // RX before TX when LSR=21
    lsr_val = 8'h00;
    repeat (4) @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rbr_val = 8'h5C;
    mark    = n_xfer;
    lsr_val = 8'h21;
    wait_xfer("prio_thr", mark, 0, 1, iw);
    wait_xfer("prio_rbr", mark, 0, 0, ir);
    check("rx_before_tx", (ir >= 0 && ir < iw), 1);
    if (iw >= 0) check("prio_thr_dat", log_dat[iw], 8'h3C);
    check("rx_data", rx_data, 8'h5C);
    check("rx_valid", rx_valid, 1);

    // RX back-pressure: only LSR polls while full
    lsr_val = 8'h01;
    mark    = n_xfer;
    repeat (30) @(negedge clk);
    check("no_rbr_full", count_xfer(mark, 0, 0), 0);
    check("polls_full", count_xfer(mark, 5, 0) > 5, 1);
    check("rx_hold", rx_data, 8'h5C);
    rbr_val  = 8'h77;
    mark     = n_xfer;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_clear", rx_valid, 0);
    wait_xfer("rbr_next", mark, 0, 0, ir);
    check("rx_data2", rx_data, 8'h77);
    check("rx_valid2", rx_valid, 1);
    lsr_val = 8'h00;

    // Ack timeout on an LSR poll
    c = 0;
    while (cyc && c < 50) begin
      @(negedge clk);
      c++;
    end
    ack_en   = 1'b0;
    err_mark = n_err;
    c = 0;
    while (!stb && c < 50) begin
      @(negedge clk);
      c++;
    end
    tmo_adr = int'(adr);
    cnt = 0;
    while (stb && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    ack_en = 1'b1;
    check("tmo_len", cnt, 255);
    check("tmo_adr", tmo_adr, 5);
    check("err_pulse", err, 1);
    @(negedge clk);
    check("err_low", err, 0);
    mark = n_xfer;
    wait_xfer("poll_after_tmo", mark, 5, 0, ir);
    check("err_count", n_err - err_mark, 1);

    // Reset during a THR write: all drops at once, init repeats, byte lost
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    lsr_val  = 8'h20;
    c = 0;
    while (!(cyc && we && adr == 3'd0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("thr_wr_seen", (cyc && we && adr == 3'd0), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cyc", cyc, 0);
    check("mid_rst_stb", stb, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_tx_ready", tx_ready, 0);
    @(negedge clk);
    mark = n_xfer;
    rst  = 1'b0;
    wait_init("reinit_wait");
    check("reinit_count", n_xfer - mark, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("reinit%0d_adr", i), log_adr[mark+i], exp_adr[i]);
      check($sformatf("reinit%0d_dat", i), log_dat[mark+i], exp_dat[i]);
    end
    repeat (20) @(negedge clk);
    check("tx_lost", count_xfer(mark + 6, 0, 1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peripheral_uart_wb_sequencer.md
Name: peripheral_uart_wb_sequencer

Overview:
- Wishbone classic master that owns the 8-bit register port of the 16550-compatible peripheral_uart_wb.
- After reset it programs the divisor latch, line control, FIFO control and interrupt enable registers.
- It then polls LSR and moves bytes between two valid/ready byte streams and THR/RBR, so on-chip requesters never touch UART registers directly.

Parameters:
- DIVISOR, 16'd27: baud divisor written to DLL/DLM.
- LCR_VAL, 8'h03: line control value (8N1); bit 7 is ignored and forced by the FSM.
- FCR_VAL, 8'h07: FIFO control (enable, clear RX and TX FIFOs).
- IER_VAL, 8'h00: interrupt enable value.
- ACK_TIMEOUT, 8'd255: cycles to wait for wbm_ack_i before aborting a transfer.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous reset, active-high
- wbm_adr_o  out  3  UART register address
- wbm_dat_o  out  8  write data
- wbm_dat_i  in  8  read data
- wbm_we_o  out  1  write enable
- wbm_stb_o  out  1  strobe
- wbm_cyc_o  out  1  cycle
- wbm_sel_o  out  4  byte select, constant 4'b0001
- wbm_ack_i  in  1  acknowledge
- tx_data_i  in  8  byte to transmit
- tx_valid_i  in  1  tx byte valid
- tx_ready_o  out  1  tx byte accepted when tx_valid_i && tx_ready_o
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  rx byte valid
- rx_ready_i  in  1  rx byte consumed when rx_valid_o && rx_ready_i
- init_done_o  out  1  configuration complete, sticky until reset
- err_o  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (async, any state): all outputs 0 except wbm_sel_o = 4'b0001; TX and RX holding registers empty; FSM to INIT0.
- Bus cycle:
  - FSM drives adr/dat/we with cyc=stb=1 and holds them until wbm_ack_i is sampled high.
  - On the ack edge: cyc/stb drop, read data is captured, and the next state is entered.
  - At least one idle cycle (cyc=0) separates consecutive transfers.
  - A timeout counter clears at each transfer start. If it reaches ACK_TIMEOUT without ack: drop cyc/stb, pulse err_o, go to POLL. During init, restart at INIT0.
- Init sequence, 6 writes in order, one state each:
  - INIT0: adr 3 <= LCR_VAL|8'h80
  - INIT1: adr 0 <= DIVISOR[7:0]
  - INIT2: adr 1 <= DIVISOR[15:8]
  - INIT3: adr 3 <= LCR_VAL&8'h7F
  - INIT4: adr 2 <= FCR_VAL
  - INIT5: adr 1 <= IER_VAL
  - After the INIT5 ack: init_done_o=1 (registered, next cycle), then go to POLL.
- POLL: read adr 5 (LSR) and capture lsr. Then decide, in priority order:
  - lsr[0] (DR) && RX holding empty -> RXRD.
  - Else lsr[5] (THRE) && TX holding full -> TXWR.
  - Else -> POLL again.
  - RX has priority over TX.
- RXRD: read adr 0. On ack: rx_data_o <= wbm_dat_i, rx_valid_o=1 next cycle, then POLL.
- TXWR: write adr 0 <= TX holding byte. On ack the TX holding register is emptied, then POLL.
- TX holding register:
  - 1 entry. tx_ready_o = init_done_o && !tx_full (combinational).
  - A byte is captured on handshake. Acceptance is legal in any post-init state, including mid-transfer.
- RX holding register:
  - rx_valid_o and rx_data_o stay stable until the handshake, then rx_valid_o clears next cycle.
  - If a handshake coincides with RXRD completion, the new byte wins: valid stays 1 and data updates.
  - Because RXRD is only entered when RX is empty, this case occurs only if RXRD started after a clear; the rule still applies.
- Polling throughput: each LSR poll is 2 cycles minimum (transfer plus idle) with zero-wait ack.
- Byte latency: tx handshake to THR write start is ≤ 4 cycles after a THRE=1 poll completes.
- Reset mid-transfer: cyc/stb drop asynchronously. Any queued TX byte is lost.

Test Plan:
- Reset, then a slave model acking in 1 cycle -> exactly 6 writes observed: (3,83),(0,1B),(1,00),(3,03),(2,07),(1,00). init_done_o=1 after the 6th ack; tx_ready_o=0 before that.
- LSR returns 8'h20, tx byte 8'hA5 offered -> tx_ready_o drops for one holding period. Next transfer after the LSR read is a write adr 0 data A5. No write occurs while LSR=8'h00.
- LSR returns 8'h21, RBR returns 8'h5C, tx byte pending -> RBR read precedes the THR write. rx_data_o=5C, rx_valid_o=1.
- rx_ready_i held 0, LSR keeps 8'h01 -> no further RBR reads, only LSR polls. Raise rx_ready_i -> valid clears and the next RBR read follows.
- Slave never acks the LSR read -> after 255 cycles cyc/stb drop, err_o pulses once, and a new LSR poll starts.
- Assert wb_rst_i mid TX write -> cyc/stb/init_done_o=0 immediately. On release the full init sequence repeats.
